// File: rtl/alu_if.sv
// Operand/opcode bundle into the ALU and registered result/flags back out.
// Latency: none (wires only); the ALU behind it registers in one cycle.
// Backpressure: none; one operation is presented and accepted every cycle.
interface alu_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  // Requester drives operands/opcode and observes result and flags.
  modport master (
    output a, b, sel,
    input  result, carry, zero
  );

  // The ALU samples operands/opcode and drives result and flags.
  modport slave (
    input  a, b, sel,
    output result, carry, zero
  );
endinterface

// File: rtl/alu.sv
// Registered unsigned ALU: ADD/SUB/AND/OR/XOR/NOT/SHL/SHR with carry and zero flags.
// Latency: 1 cycle from sampled operands to result/carry/zero.
// Backpressure: none; accepts a new operation on every clock, no enable.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // One extra bit holds the carry-out of ADD and the borrow of SUB.
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;

  assign sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_ext = {1'b0, bus.a} - {1'b0, bus.b};

  // Select the next result and carry for the current opcode.
  always_comb begin
    nxt_result = '0;
    nxt_carry  = 1'b0;
    case (bus.sel)
      OP_ADD: begin
        nxt_result = sum_ext[WIDTH-1:0];
        nxt_carry  = sum_ext[WIDTH];
      end
      OP_SUB: begin
        // Top bit of the widened difference is set exactly when a < b.
        nxt_result = diff_ext[WIDTH-1:0];
        nxt_carry  = diff_ext[WIDTH];
      end
      OP_AND: nxt_result = bus.a & bus.b;
      OP_OR:  nxt_result = bus.a | bus.b;
      OP_XOR: nxt_result = bus.a ^ bus.b;
      OP_NOT: nxt_result = ~bus.a;
      OP_SHL: begin
        nxt_result = {bus.a[WIDTH-2:0], 1'b0};
        nxt_carry  = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        nxt_result = {1'b0, bus.a[WIDTH-1:1]};
        nxt_carry  = bus.a[0];
      end
      default: begin
        nxt_result = '0;
        nxt_carry  = 1'b0;
      end
    endcase
  end

  // Register result and flags; zero tracks the freshly computed result, reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result <= '0;
      bus.carry  <= 1'b0;
      bus.zero   <= 1'b1;
    end else begin
      bus.result <= nxt_result;
      bus.carry  <= nxt_carry;
      bus.zero   <= (nxt_result == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed plan vectors with fixed expectations, then random vectors.
// Latency: checks outputs 1 ns after each rising edge against the operation sampled there.
// Backpressure: none; one vector per cycle.
module tb_alu;
  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_if #(.WIDTH(W)) bus ();

  alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: arithmetic on plain integers straight from the operation table.
  task automatic ref_model(input int a, input int b, input int sel, input bit r,
                           output int res, output int cy, output int zf);
    int full;
    full = 0;
    cy   = 0;
    if (r) begin
      res = 0;
      cy  = 0;
    end else begin
      case (sel)
        0: begin full = a + b; res = full % (MASK + 1); cy = (full > MASK) ? 1 : 0; end
        1: begin res = (a - b + MASK + 1) % (MASK + 1); cy = (a < b) ? 1 : 0; end
        2: res = a & b;
        3: res = a | b;
        4: res = a ^ b;
        5: res = MASK - a;
        6: begin res = (a * 2) % (MASK + 1); cy = a / (1 << (W - 1)); end
        default: begin res = a / 2; cy = a % 2; end
      endcase
    end
    zf = (res == 0) ? 1 : 0;
  endtask

  // Drive one vector, clock it in, and leave the bench 1 ns past the edge.
  task automatic apply(input int a, input int b, input int sel, input bit r);
    bus.a   = a[W-1:0];
    bus.b   = b[W-1:0];
    bus.sel = sel[2:0];
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  // Directed vector with expectations written out by hand.
  task automatic dir(input string tag, input int a, input int b, input int sel, input bit r,
                     input int er, input int ec, input int ez);
    apply(a, b, sel, r);
    check({tag, ".result"}, int'(bus.result), er);
    check({tag, ".carry"},  int'(bus.carry),  ec);
    check({tag, ".zero"},   int'(bus.zero),   ez);
  endtask

  // Vector checked against the reference model.
  task automatic mdl(input string tag, input int a, input int b, input int sel, input bit r);
    int er, ec, ez;
    ref_model(a, b, sel, r, er, ec, ez);
    apply(a, b, sel, r);
    check({tag, ".result"}, int'(bus.result), er);
    check({tag, ".carry"},  int'(bus.carry),  ec);
    check({tag, ".zero"},   int'(bus.zero),   ez);
  endtask

  // Main sequence: reset, plan vectors, hold, sweep, mid-stream reset, random.
  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    bus.a   = '0;
    bus.b   = '0;
    bus.sel = '0;
    @(negedge clk);

    dir("rst0", 15, 15, 0, 1, 0, 0, 1);
    dir("rst1", 15, 15, 0, 1, 0, 0, 1);
    dir("first_add", 5, 3, 0, 0, 8, 0, 0);

    dir("add", 5, 3, 0, 0, 8, 0, 0);
    dir("sub", 5, 3, 1, 0, 2, 0, 0);
    dir("add_wrap", 15, 1, 0, 0, 0, 1, 1);
    dir("sub_borrow", 3, 5, 1, 0, 14, 1, 0);

    dir("and", 5, 3, 2, 0, 1, 0, 0);
    dir("or", 5, 3, 3, 0, 7, 0, 0);
    dir("xor", 5, 3, 4, 0, 6, 0, 0);
    dir("not", 5, 0, 5, 0, 10, 0, 0);
    dir("not_zero", 15, 0, 5, 0, 0, 0, 1);

    dir("shl", 3, 0, 6, 0, 6, 0, 0);
    dir("shr", 12, 0, 7, 0, 6, 0, 0);
    dir("shl_out", 9, 0, 6, 0, 2, 1, 0);
    dir("shr_out", 9, 0, 7, 0, 4, 1, 0);

    // Inputs moving between edges must not reach the outputs.
    bus.a   = 4'h0;
    bus.sel = 3'b000;
    #3;
    check("hold.result", int'(bus.result), 4);
    check("hold.carry",  int'(bus.carry),  1);
    check("hold.zero",   int'(bus.zero),   0);

    // Every opcode back-to-back, each visible exactly one edge later.
    for (int s = 0; s < 8; s++) begin
      mdl($sformatf("sweep%0d", s), 10, 6, s, 0);
    end

    // One-edge reset inside a run of ADDs.
    dir("mid_pre", 1, 1, 0, 0, 2, 0, 0);
    dir("mid_rst", 2, 3, 0, 1, 0, 0, 1);
    dir("mid_post", 3, 4, 0, 0, 7, 0, 0);

    for (int i = 0; i < 400; i++) begin
      mdl($sformatf("rnd%0d", i), int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
          int'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
